// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-channel mux arbiter front-end.
package mux_arb_pkg;

    // Output register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    // Channel indices, also the mux select encoding
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Width of the optional per-channel grant counters
    localparam int unsigned ARB_CNT_W = 16;

endpackage : mux_arb_pkg

// File: rtl/mux2x1_arb_ctrl_if.sv
// Handshake/data bundle between two input streams, the arbiter and the
// merged output stream. The slave modport is the arbiter's view.
interface mux2x1_arb_ctrl_if #(
    parameter int W = 1
);
    logic         in0_valid;
    logic [W-1:0] in0_data;
    logic         in0_ready;
    logic         in1_valid;
    logic [W-1:0] in1_data;
    logic         in1_ready;
    logic         s;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, s, out_valid, out_data
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, s, out_valid, out_data
    );
endinterface : mux2x1_arb_ctrl_if

// File: rtl/mux2x1_vec.sv
// W-bit combinational 2:1 multiplexer: y = s ? a1 : a0.
module mux2x1_vec #(
    parameter int W = 1
) (
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic         s,
    output logic [W-1:0] y
);

    // Select between the two words
    always_comb begin
        y = s ? a1 : a0;
    end

endmodule : mux2x1_vec

// File: rtl/mux2x1_arb_ctrl.sv
// Round-robin arbiter for two valid/ready streams feeding a 2:1 mux, with a
// one-entry registered output stage. Owns the mux select line.
// Optional build macro: MUX_ARB_STATS_EN adds saturating per-channel
// grant counters grant0_cnt / grant1_cnt.
module mux2x1_arb_ctrl
    import mux_arb_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mux2x1_arb_ctrl_if.slave     bus
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [ARB_CNT_W-1:0] grant0_cnt,
    output logic [ARB_CNT_W-1:0] grant1_cnt
`endif
);

    arb_state_e   state;
    arb_state_e   state_nxt;
    logic         last;
    logic         load_en;
    logic         gnt_vld;
    logic         gnt_ch;
    logic         sel;
    logic [W-1:0] mux_y;
    logic [W-1:0] data_q;

    // Grant, load enable and next-state; reset forces no grant so s and the
    // readies drop immediately rather than at the next edge
    always_comb begin
        load_en   = (state == EMPTY) | bus.out_ready;
        gnt_vld   = 1'b0;
        gnt_ch    = CH0;
        state_nxt = state;
        if (!rst && load_en) begin
            unique case ({bus.in1_valid, bus.in0_valid})
                2'b01:   begin gnt_vld = 1'b1; gnt_ch = CH0;   end
                2'b10:   begin gnt_vld = 1'b1; gnt_ch = CH1;   end
                2'b11:   begin gnt_vld = 1'b1; gnt_ch = ~last; end
                default: begin gnt_vld = 1'b0; gnt_ch = CH0;   end
            endcase
        end
        if (gnt_vld) begin
            state_nxt = FULL;
        end else if (bus.out_ready) begin
            state_nxt = EMPTY;
        end
    end

    assign sel           = gnt_vld & gnt_ch;
    assign bus.s         = sel;
    assign bus.in0_ready = gnt_vld & (gnt_ch == CH0);
    assign bus.in1_ready = gnt_vld & (gnt_ch == CH1);
    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;

    mux2x1_vec #(.W(W)) u_mux (
        .a0 (bus.in0_data),
        .a1 (bus.in1_data),
        .s  (sel),
        .y  (mux_y)
    );

    // Occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output word and round-robin pointer update on each grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            last   <= CH1;
        end else if (gnt_vld) begin
            data_q <= mux_y;
            last   <= gnt_ch;
        end
    end

`ifdef MUX_ARB_STATS_EN
    // Saturating per-channel accept counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else begin
            if (bus.in0_ready && grant0_cnt != '1) begin
                grant0_cnt <= grant0_cnt + 1'b1;
            end
            if (bus.in1_ready && grant1_cnt != '1) begin
                grant1_cnt <= grant1_cnt + 1'b1;
            end
        end
    end
`endif

endmodule : mux2x1_arb_ctrl
